conv_encoder: RTL and testbench
===============================

// Module: conv_encoder
// PURPOSE
//  Rate-1/2 convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder
//  (branch, add-compare, memory, traceback).
//  Takes one frame of FRAME_LEN data bits over a valid/ready input and appends K-1 zero tail
//  bits to flush the encoder. It emits one 2-bit code symbol per bit over a valid/ready output.
//  The symbol stream feeds the decoder test path directly.
// PARAMETERS
//  K          3       constraint length; shift register holds K-1 bits
//  G0         3'b111  generator for sym[1]; bit K-1 taps the current input bit
//  G1         3'b101  generator for sym[0]; bit 0 taps the oldest register bit
//  FRAME_LEN  8       data bits per frame (>=1)
//  CW         4       counter width; must satisfy 2**CW > FRAME_LEN+K-1
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  reset, asynchronous, active-high
//  en         in   1  global enable; 0 freezes all state, in_ready=0, outputs held
//  start      in   1  1-cycle pulse; begins a frame (honoured only in IDLE with en=1)
//  in_bit     in   1  data bit
//  in_valid   in   1  in_bit valid
//  in_ready   out  1  encoder accepts in_bit this cycle
//  sym        out  2  code symbol {c0,c1}; sym[1]=parity(G0&w), sym[0]=parity(G1&w)
//  out_valid  out  1  sym valid
//  out_ready  in   1  downstream accepts sym
//  busy       out  1  state != IDLE
//  done       out  1  1-cycle pulse when the last tail symbol is accepted
// BEHAVIOUR
//  Reset: state=IDLE, sr=0, cnt=0, sym=0, out_valid=0, in_ready=0, busy=0, done=0.
//  Window: w = {in_bit, sr[0], ..., sr[K-2]}, with w[K-1] = newest bit. On each encode step:
//   sr <= {sr[K-3:0], bit}, so sr[0] always holds the most recent bit.
//  Output stage: a single register (sym, out_valid).
//   - The stage can load when !out_valid || out_ready ("slot free").
//   - out_valid clears on out_ready when nothing new is loaded.
//   - sym holds stable while out_valid=1 && out_ready=0.
//  FSM (advances only when en=1):
//   IDLE: sr<=0, cnt<=0. On start: go to ENC.
//   ENC:  in_ready = slot free.
//         On in_valid && in_ready: encode in_bit, load sym, set out_valid, cnt++.
//         When the FRAME_LEN-th bit is accepted: cnt<=0, go to TAIL.
//   TAIL: in_ready=0. Whenever the slot is free: encode bit 0, load sym, cnt++.
//         After K-1 tail symbols are loaded: go to DRAIN.
//   DRAIN: wait for out_ready on the last symbol.
//          Then: done=1 for one cycle, out_valid<=0, go to IDLE.
//  Latency: sym is valid on the cycle after the input handshake.
//   Full throughput (1 bit/clk) when out_ready=1.
//  Boundaries:
//   - start while busy: ignored.
//   - start and in_valid in the same IDLE cycle: the bit is not accepted (in_ready=0).
//   - out_ready=0 stall: in_ready=0, no bit is lost, sym held.
//   - en=0 during a handshake cycle: no transfer occurs on either side.
//   - rst mid-frame: immediate return to the reset values; the partial frame is discarded.
//   - Counters never wrap inside a frame; cnt resets at each phase boundary.
// STRUCTURE
//  Shared package/header viterbi_defs: K, G0, G1, FRAME_LEN, CW, and state encodings
//   S_IDLE, S_ENC, S_TAIL, S_DRAIN (3'b000..3'b011). The decoder uses the same K/G values.
//  One natural sub-module: conv_enc_core, purely combinational: (bit, sr) -> (sym, sr_next).
//  FSM, counters and output register live in conv_encoder.
// TESTING (K=3, G0=7, G1=5, FRAME_LEN=4 unless noted)
//  1. Bits 1,0,1,1 with out_ready=1 -> syms 11,10,00,01, then tail 01,11.
//     done pulses once, busy falls the next cycle.
//  2. Same frame, out_ready toggled 1/0 each cycle -> identical sym sequence.
//     sym stable while stalled, in_ready=0 while stalled.
//  3. Assert rst after the 2nd accepted bit -> all outputs 0 immediately.
//     A new frame 1,1,1,1 then gives 11,01,10,10,01,11.
//  4. start pulsed during ENC and TAIL -> no effect; frame completes with 6 syms.
//  5. Hold en=0 for 5 cycles mid-frame -> no handshakes, outputs frozen.
//     Resuming gives the same output as scenario 1.
//  6. FRAME_LEN=8, all zeros, back-to-back frames -> 10 syms of 00 per frame.
//     done pulses once per frame.

Source files
------------

// File: rtl/conv_encoder_pkg.sv
// Shared encoder/decoder definitions: code parameters and FSM state encodings.
// The Viterbi decoder imports the same K/G values.
package conv_encoder_pkg;

    localparam int K = 3;
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;
    localparam int FRAME_LEN = 8;
    localparam int CW = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_ENC   = 3'b001,
        S_TAIL  = 3'b010,
        S_DRAIN = 3'b011
    } state_t;

endpackage

// File: rtl/conv_encoder_if.sv
// Control, input-bit and output-symbol handshake bundle of the encoder.
// master drives the frame; slave is the encoder.
interface conv_encoder_if;

    logic       en;
    logic       start;
    logic       in_bit;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] sym;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    modport master (
        output en, start, in_bit, in_valid, out_ready,
        input  in_ready, sym, out_valid, busy, done
    );

    modport slave (
        input  en, start, in_bit, in_valid, out_ready,
        output in_ready, sym, out_valid, busy, done
    );

endinterface

// File: rtl/conv_encoder_core.sv
// Combinational encode step: one bit plus shift register gives
// the code symbol and the next shift register contents.
module conv_encoder_core
    import conv_encoder_pkg::*;
(
    input  logic         din,
    input  logic [K-2:0] sr,
    output logic [1:0]   sym,
    output logic [K-2:0] sr_next
);

    logic [K-1:0] w;
    logic [K-1:0] shifted;

    // Window: newest bit at the top, oldest register bit at bit 0
    always_comb begin
        w = '0;
        w[K-1] = din;
        for (int i = 0; i < K-1; i++) begin
            w[K-2-i] = sr[i];
        end
    end

    assign sym = {^(G0 & w), ^(G1 & w)};
    assign shifted = {sr, din};
    assign sr_next = shifted[K-2:0];

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 frame encoder: accepts FRAME_N data bits, appends K-1 zero
// tail bits and streams one registered 2-bit symbol per bit.
module conv_encoder
    import conv_encoder_pkg::*;
#(
    parameter int FRAME_N = FRAME_LEN,
    parameter int CNT_W   = CW
) (
    input logic           clk,
    input logic           rst,
    conv_encoder_if.slave bus
);

    state_t state;
    state_t state_next;

    logic [K-2:0]     sr;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sym_q;
    logic             vld_q;

    logic             slot_free;
    logic             accept;
    logic             tail_load;
    logic             load;
    logic             enc_bit;
    logic             last_bit;
    logic             last_tail;
    logic             drain_ack;
    logic [1:0]       sym_c;
    logic [K-2:0]     sr_c;

    assign slot_free = !vld_q || bus.out_ready;
    assign accept    = bus.en && (state == S_ENC) && slot_free && bus.in_valid;
    assign tail_load = bus.en && (state == S_TAIL) && slot_free;
    assign load      = accept || tail_load;
    assign enc_bit   = (state == S_ENC) && bus.in_bit;
    assign last_bit  = (cnt == CNT_W'(FRAME_N - 1));
    assign last_tail = (cnt == CNT_W'(K - 2));
    assign drain_ack = bus.en && (state == S_DRAIN) && vld_q && bus.out_ready;

    conv_encoder_core u_core (
        .din     (enc_bit),
        .sr      (sr),
        .sym     (sym_c),
        .sr_next (sr_c)
    );

    // State register, frozen while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (bus.en) begin
            state <= state_next;
        end
    end

    // Next-state: frame phases ENC -> TAIL -> DRAIN -> IDLE
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (bus.start) state_next = S_ENC;
            S_ENC:   if (accept && last_bit) state_next = S_TAIL;
            S_TAIL:  if (tail_load && last_tail) state_next = S_DRAIN;
            S_DRAIN: if (drain_ack) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs: input ready, busy flag and end-of-frame pulse
    always_comb begin
        bus.in_ready = bus.en && (state == S_ENC) && slot_free;
        bus.busy     = (state != S_IDLE);
        bus.done     = drain_ack;
    end

    // Shift register and per-phase counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (bus.en) begin
            if (state == S_IDLE) begin
                sr  <= '0;
                cnt <= '0;
            end else if (load) begin
                sr <= sr_c;
                if ((accept && last_bit) || (tail_load && last_tail)) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // Output register: load when the slot frees, hold while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_q <= '0;
            vld_q <= 1'b0;
        end else if (bus.en) begin
            if (load) begin
                sym_q <= sym_c;
                vld_q <= 1'b1;
            end else if (bus.out_ready) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign bus.sym       = sym_q;
    assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: convolution model with symbol queue, directed
// frames, reset/enable/stall cases and randomized traffic.
module tb_conv_encoder;

    localparam int TK = 3;
    localparam logic [2:0] TG0 = 3'b111;
    localparam logic [2:0] TG1 = 3'b101;
    localparam int FL = 4;

    logic clk;
    logic rst;

    conv_encoder_if bus4();
    conv_encoder_if bus8();

    conv_encoder #(.FRAME_N(FL), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    conv_encoder dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model state
    logic       fb[$];
    logic [1:0] exp_q[$];
    bit         last_q[$];
    logic [1:0] obs[$];
    bit         mbusy = 0;
    int         nbits = 0;
    int         ndone = 0;
    bit         p_hold = 0;
    logic [1:0] p_sym = '0;

    int  rdy_mode = 0;
    bit  en_rand = 0;
    bit  gaps = 0;

    // Symbol at step n: XOR of generator taps over the frame bits,
    // with zeros before the frame and after its end (tail)
    function automatic logic [1:0] conv_at(int n);
        logic a, b, x;
        int idx;
        a = 1'b0;
        b = 1'b0;
        for (int j = 0; j < TK; j++) begin
            idx = n - j;
            x = (idx >= 0 && idx < fb.size()) ? fb[idx] : 1'b0;
            a = a ^ (TG0[TK-1-j] & x);
            b = b ^ (TG1[TK-1-j] & x);
        end
        return {a, b};
    endfunction

    // Compare process for the FRAME_LEN=4 instance
    always @(negedge clk) begin
        bit hs_in, hs_out, exp_done, l, exp_ir;
        logic [1:0] e;
        if (rst) begin
            fb.delete();
            exp_q.delete();
            last_q.delete();
            mbusy = 0;
            nbits = 0;
            p_hold = 0;
        end else begin
            hs_in  = bus4.en && bus4.in_valid && bus4.in_ready;
            hs_out = bus4.en && bus4.out_valid && bus4.out_ready;
            exp_ir = bus4.en && mbusy && (nbits < FL) &&
                     (!bus4.out_valid || bus4.out_ready);
            chk("in_ready", 32'(bus4.in_ready), 32'(exp_ir));
            chk("busy", 32'(bus4.busy), 32'(mbusy));
            if (p_hold) begin
                chk("held_valid", 32'(bus4.out_valid), 32'(1));
                chk("held_sym", 32'(bus4.sym), 32'(p_sym));
            end
            exp_done = 0;
            if (hs_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_sym", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    l = last_q.pop_front();
                    chk("sym", 32'(bus4.sym), 32'(e));
                    exp_done = l;
                    obs.push_back(bus4.sym);
                end
            end
            chk("done", 32'(bus4.done), 32'(exp_done));
            if (bus4.done) ndone++;
            if (hs_in) begin
                fb.push_back(bus4.in_bit);
                exp_q.push_back(conv_at(nbits));
                last_q.push_back(1'b0);
                nbits++;
                if (nbits == FL) begin
                    for (int t = 0; t < TK-1; t++) begin
                        exp_q.push_back(conv_at(FL + t));
                        last_q.push_back(t == TK-2);
                    end
                end
            end
            if (!mbusy) begin
                if (bus4.en && bus4.start) begin
                    mbusy = 1;
                    nbits = 0;
                    fb.delete();
                end
            end else if (exp_done) begin
                mbusy = 0;
            end
            p_hold = bus4.out_valid && !hs_out;
            p_sym  = bus4.sym;
        end
    end

    // FRAME_LEN=8 instance: count zero symbols per frame
    int n8 = 0;
    int d8 = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus8.en && bus8.out_valid && bus8.out_ready) begin
                chk("s6_sym", 32'(bus8.sym), 32'(0));
                n8++;
            end
            if (bus8.done) begin
                chk("s6_syms_per_frame", 32'(n8), 32'(10));
                n8 = 0;
                d8++;
            end
        end
    end

    // Background out_ready / enable pattern
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: bus4.out_ready = 1'b1;
                1: bus4.out_ready = ~bus4.out_ready;
                default: bus4.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (en_rand) bus4.en = ($urandom_range(0, 7) != 0);
        end
    end

    task automatic start_frame(input bit with_bit);
        bit seen;
        int g;
        seen = 0;
        g = 0;
        bus4.start = 1'b1;
        bus4.in_valid = with_bit;
        bus4.in_bit = 1'b1;
        while (!seen && g < 100) begin
            @(negedge clk);
            seen = bus4.en;
            if (with_bit && seen) chk("start_cycle_in_ready", 32'(bus4.in_ready), 32'(0));
            @(posedge clk);
            #1;
            g++;
        end
        chk("start_timeout", 32'(seen), 32'(1));
        bus4.start = 1'b0;
        bus4.in_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int lo, input int hi,
                             input int start_at);
        bit took;
        int g;
        for (int i = lo; i <= hi; i++) begin
            took = 0;
            g = 0;
            bus4.in_bit = bits[i];
            bus4.in_valid = 1'b1;
            if (i == start_at) bus4.start = 1'b1;
            while (!took && g < 200) begin
                @(negedge clk);
                took = bus4.en && bus4.in_valid && bus4.in_ready;
                @(posedge clk);
                #1;
                bus4.start = 1'b0;
                g++;
            end
            chk("in_handshake_timeout", 32'(took), 32'(1));
            bus4.in_valid = 1'b0;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        int g;
        seen = 0;
        g = 0;
        while (!seen && g < 300) begin
            @(negedge clk);
            seen = (bus4.done === 1'b1);
            g++;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'(1));
        @(posedge clk);
        #1;
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'(0));
    endtask

    task automatic check_obs(input string tag, input logic [11:0] exp6);
        logic [11:0] e;
        e = exp6;
        chk({tag, "_nsyms"}, 32'(obs.size()), 32'(6));
        for (int i = 0; i < 6 && i < obs.size(); i++) begin
            chk({tag, "_lit_sym"}, 32'(obs[i]), 32'(e[11-2*i -: 2]));
        end
    endtask

    // 1,0,1,1 -> 11,10,00,01,01,11 ; 1,1,1,1 -> 11,01,10,10,01,11
    localparam logic [11:0] LIT_1011 = 12'b11_10_00_01_01_11;
    localparam logic [11:0] LIT_1111 = 12'b11_01_10_10_01_11;

    initial begin
        logic [1:0] snap_sym;
        logic snap_v, snap_b;
        int d0, g;
        logic [15:0] rb;

        bus4.en = 1'b1;
        bus4.start = 1'b0;
        bus4.in_bit = 1'b0;
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b1;
        bus8.en = 1'b1;
        bus8.start = 1'b0;
        bus8.in_bit = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sym", 32'(bus4.sym), 32'(0));
        chk("rst_out_valid", 32'(bus4.out_valid), 32'(0));
        chk("rst_in_ready", 32'(bus4.in_ready), 32'(0));
        chk("rst_busy", 32'(bus4.busy), 32'(0));
        chk("rst_done", 32'(bus4.done), 32'(0));
        chk("rst8_busy", 32'(bus8.busy), 32'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: full throughput, start with in_valid in same cycle
        obs.delete();
        d0 = ndone;
        start_frame(1'b1);
        send_bits(16'b1101, 0, 3, -1);
        wait_done("s1");
        check_obs("s1", LIT_1011);
        chk("s1_done_once", 32'(ndone - d0), 32'(1));
        chk("s1_busy_after", 32'(bus4.busy), 32'(0));

        // 2: out_ready toggling
        rdy_mode = 1;
        obs.delete();
        start_frame(1'b0);
        send_bits(16'b1101, 0, 3, -1);
        wait_done("s2");
        check_obs("s2", LIT_1011);
        rdy_mode = 0;

        // 3: reset after second accepted bit
        start_frame(1'b0);
        send_bits(16'b1101, 0, 1, -1);
        rst = 1'b1;
        #1;
        chk("s3_sym", 32'(bus4.sym), 32'(0));
        chk("s3_out_valid", 32'(bus4.out_valid), 32'(0));
        chk("s3_in_ready", 32'(bus4.in_ready), 32'(0));
        chk("s3_busy", 32'(bus4.busy), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        obs.delete();
        start_frame(1'b0);
        send_bits(16'b1111, 0, 3, -1);
        wait_done("s3");
        check_obs("s3", LIT_1111);

        // 4: start pulses during ENC and TAIL
        obs.delete();
        start_frame(1'b0);
        send_bits(16'b1101, 0, 3, 1);
        bus4.start = 1'b1;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        wait_done("s4");
        check_obs("s4", LIT_1011);
        repeat (3) @(posedge clk);
        #1;
        chk("s4_idle_after", 32'(bus4.busy), 32'(0));

        // 5: enable low for 5 cycles mid-frame
        obs.delete();
        start_frame(1'b0);
        send_bits(16'b1101, 0, 1, -1);
        bus4.en = 1'b0;
        bus4.in_valid = 1'b1;
        bus4.in_bit = 1'b1;
        @(negedge clk);
        snap_sym = bus4.sym;
        snap_v = bus4.out_valid;
        snap_b = bus4.busy;
        repeat (5) begin
            @(negedge clk);
            chk("s5_frozen_sym", 32'(bus4.sym), 32'(snap_sym));
            chk("s5_frozen_valid", 32'(bus4.out_valid), 32'(snap_v));
            chk("s5_frozen_busy", 32'(bus4.busy), 32'(snap_b));
        end
        @(posedge clk);
        #1;
        bus4.en = 1'b1;
        bus4.in_valid = 1'b0;
        send_bits(16'b1101, 2, 3, -1);
        wait_done("s5");
        check_obs("s5", LIT_1011);

        // Randomized frames with stalls, gaps and enable drops
        rdy_mode = 2;
        en_rand = 1;
        gaps = 1;
        for (int f = 0; f < 15; f++) begin
            rb = 16'($urandom);
            start_frame(1'($urandom_range(0, 1)));
            send_bits(rb, 0, FL-1, $urandom_range(0, 5));
            wait_done("rand");
        end
        en_rand = 0;
        gaps = 0;
        rdy_mode = 0;
        bus4.en = 1'b1;

        // 6: FRAME_LEN=8 back-to-back all-zero frames
        bus8.in_bit = 1'b0;
        bus8.in_valid = 1'b1;
        for (int f = 0; f < 2; f++) begin
            bus8.start = 1'b1;
            @(posedge clk);
            #1;
            bus8.start = 1'b0;
            g = 0;
            while (bus8.done !== 1'b1 && g < 100) begin
                @(posedge clk);
                #1;
                g++;
            end
            chk("s6_done_timeout", 32'(bus8.done), 32'(1));
            @(posedge clk);
            #1;
        end
        bus8.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("s6_done_count", 32'(d8), 32'(2));
        chk("s6_busy_after", 32'(bus8.busy), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
